// File: rtl/agc_pkg.sv
// Shared AGC definitions: default datapath widths, unity gain and output clamp limits.
package agc_pkg;

  localparam int unsigned DEF_W_IN      = 26;
  localparam int unsigned DEF_W_GAIN    = 16;
  localparam int unsigned DEF_GAIN_FRAC = 12;
  localparam int unsigned DEF_W_OUT     = 26;
  localparam int unsigned DEF_W_CNT     = 16;

  function automatic longint unsigned unity_gain(input int unsigned frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint out_max(input int unsigned w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint out_min(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/mul_round_sat.sv
// One channel of the gain stage: multiply by unsigned gain, round half-up, saturate.
module mul_round_sat
  import agc_pkg::*;
#(
  parameter int unsigned W_IN      = DEF_W_IN,
  parameter int unsigned W_GAIN    = DEF_W_GAIN,
  parameter int unsigned GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int unsigned W_OUT     = DEF_W_OUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_IN-1:0]   i_sample,
  input  logic [W_GAIN-1:0] i_gain,
  input  logic              i_en,
  output logic [W_OUT-1:0]  o_data,
  output logic              o_clip
);

  localparam int unsigned W_P = W_IN + W_GAIN + 1;
  localparam int unsigned W_S = W_P - GAIN_FRAC;

  localparam logic signed [W_P-1:0]   HALF    = W_P'(1) <<< (GAIN_FRAC - 1);
  localparam logic signed [W_OUT-1:0] SAT_MAX = W_OUT'(out_max(W_OUT));
  localparam logic signed [W_OUT-1:0] SAT_MIN = W_OUT'(out_min(W_OUT));

  logic signed [W_P-1:0]   r_prod;
  logic signed [W_S-1:0]   r_shift;
  logic signed [W_OUT-1:0] w_sat;
  logic                    w_clip;
  logic signed [W_OUT-1:0] r_out;

  // Gain is zero-extended so a set MSB never reads as negative.
  always_ff @(posedge clk) begin
    r_prod  <= W_P'($signed(i_sample)) * W_P'($signed({1'b0, i_gain}));
    r_shift <= W_S'((r_prod + HALF) >>> GAIN_FRAC);
  end

  if (W_S > W_OUT) begin : g_sat
    logic [W_S-W_OUT:0] w_hi;
    logic               w_pos_ovf;
    logic               w_neg_ovf;

    // Fits iff every bit above the output sign bit matches the sign.
    assign w_hi      = r_shift[W_S-1:W_OUT-1];
    assign w_pos_ovf = ~r_shift[W_S-1] & (|w_hi);
    assign w_neg_ovf = r_shift[W_S-1] & ~(&w_hi);

    always_comb begin
      w_sat = r_shift[W_OUT-1:0];
      if (w_pos_ovf) begin
        w_sat = SAT_MAX;
      end else if (w_neg_ovf) begin
        w_sat = SAT_MIN;
      end
    end

    assign w_clip = w_pos_ovf | w_neg_ovf;
  end else begin : g_ext
    assign w_sat  = W_OUT'(r_shift);
    assign w_clip = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (i_en) begin
      r_out <= w_sat;
    end
  end

  assign o_data = r_out;
  assign o_clip = w_clip;

endmodule

// File: rtl/iq_gain_apply.sv
// AGC forward-path gain: scales I/Q by a registered gain, rounds, saturates, counts clips.
module iq_gain_apply
  import agc_pkg::*;
#(
  parameter int unsigned W_IN      = DEF_W_IN,
  parameter int unsigned W_GAIN    = DEF_W_GAIN,
  parameter int unsigned GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int unsigned W_OUT     = DEF_W_OUT,
  parameter int unsigned W_CNT     = DEF_W_CNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_IN-1:0]   Input_i,
  input  logic [W_IN-1:0]   Input_q,
  input  logic              Valid,
  input  logic [W_GAIN-1:0] Gain,
  input  logic              Gain_valid,
  input  logic              Sat_clear,
  output logic [W_OUT-1:0]  Output_i,
  output logic [W_OUT-1:0]  Output_q,
  output logic              Valid_out,
  output logic [W_CNT-1:0]  Sat_count
);

  localparam logic [W_GAIN-1:0] UNITY = W_GAIN'(unity_gain(GAIN_FRAC));

  logic [W_GAIN-1:0] r_gain;
  logic [W_GAIN-1:0] r_s1_gain;
  logic [W_IN-1:0]   r_s1_i;
  logic [W_IN-1:0]   r_s1_q;
  logic              r_v1;
  logic              r_v2;
  logic              r_v3;
  logic              r_vout;
  logic [W_CNT-1:0]  r_cnt;
  logic              w_clip_i;
  logic              w_clip_q;
  logic              w_clip;

  // A sample captured alongside Gain_valid takes the old gain from r_gain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain <= UNITY;
    end else if (Gain_valid) begin
      r_gain <= Gain;
    end
  end

  always_ff @(posedge clk) begin
    if (Valid) begin
      r_s1_i    <= Input_i;
      r_s1_q    <= Input_q;
      r_s1_gain <= r_gain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_vout <= 1'b0;
    end else begin
      r_v1   <= Valid;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_vout <= r_v3;
    end
  end

  mul_round_sat #(
    .W_IN      (W_IN),
    .W_GAIN    (W_GAIN),
    .GAIN_FRAC (GAIN_FRAC),
    .W_OUT     (W_OUT)
  ) u_chan_i (
    .clk      (clk),
    .rst      (rst),
    .i_sample (r_s1_i),
    .i_gain   (r_s1_gain),
    .i_en     (r_v3),
    .o_data   (Output_i),
    .o_clip   (w_clip_i)
  );

  mul_round_sat #(
    .W_IN      (W_IN),
    .W_GAIN    (W_GAIN),
    .GAIN_FRAC (GAIN_FRAC),
    .W_OUT     (W_OUT)
  ) u_chan_q (
    .clk      (clk),
    .rst      (rst),
    .i_sample (r_s1_q),
    .i_gain   (r_s1_gain),
    .i_en     (r_v3),
    .o_data   (Output_q),
    .o_clip   (w_clip_q)
  );

  assign w_clip = w_clip_i | w_clip_q;

  // Clear beats a coincident increment; the count saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (rst || Sat_clear) begin
      r_cnt <= '0;
    end else if (r_v3 && w_clip && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W_CNT'(1);
    end
  end

  assign Valid_out = r_vout;
  assign Sat_count = r_cnt;

endmodule

// File: tb/tb_iq_gain_apply.sv
// Directed self-checking bench for iq_gain_apply (default counter and a 4-bit counter copy).
module tb_iq_gain_apply;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [25:0] Input_i = '0;
  logic signed [25:0] Input_q = '0;
  logic               Valid = 1'b0;
  logic [15:0]        Gain = '0;
  logic               Gain_valid = 1'b0;
  logic               Sat_clear = 1'b0;

  logic signed [25:0] Output_i;
  logic signed [25:0] Output_q;
  logic               Valid_out;
  logic [15:0]        Sat_count;

  logic signed [25:0] Output_i4;
  logic signed [25:0] Output_q4;
  logic               Valid_out4;
  logic [3:0]         Sat_count4;

  int n_vec = 0;
  int n_err = 0;

  localparam logic signed [25:0] BIG_P = 26'sd16777216;
  localparam logic signed [25:0] BIG_N = -26'sd16777216;
  localparam logic signed [25:0] MAXV  = 26'sd33554431;
  localparam logic signed [25:0] MINV  = -26'sd33554432;

  always #5 clk = ~clk;

  iq_gain_apply dut (
    .clk        (clk),
    .rst        (rst),
    .Input_i    (Input_i),
    .Input_q    (Input_q),
    .Valid      (Valid),
    .Gain       (Gain),
    .Gain_valid (Gain_valid),
    .Sat_clear  (Sat_clear),
    .Output_i   (Output_i),
    .Output_q   (Output_q),
    .Valid_out  (Valid_out),
    .Sat_count  (Sat_count)
  );

  iq_gain_apply #(.W_CNT(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .Input_i    (Input_i),
    .Input_q    (Input_q),
    .Valid      (Valid),
    .Gain       (Gain),
    .Gain_valid (Gain_valid),
    .Sat_clear  (Sat_clear),
    .Output_i   (Output_i4),
    .Output_q   (Output_q4),
    .Valid_out  (Valid_out4),
    .Sat_count  (Sat_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [25:0] si, input logic signed [25:0] sq);
    Input_i = si;
    Input_q = sq;
    Valid   = 1'b1;
    tick();
    Valid   = 1'b0;
  endtask

  task automatic load_gain(input logic [15:0] g);
    Gain       = g;
    Gain_valid = 1'b1;
    tick();
    Gain_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_vout", Valid_out, 0);
    chk("rst_oi", Output_i, 0);
    chk("rst_oq", Output_q, 0);
    chk("rst_cnt", Sat_count, 0);
    chk("rst_cnt4", Sat_count4, 0);
    rst = 1'b0;

    // Unity gain, 3-cycle latency, one-cycle pulse
    send(26'sd1000, -26'sd1000);
    tick();
    chk("unity_early", Valid_out, 0);
    tick();
    tick();
    chk("unity_vout", Valid_out, 1);
    chk("unity_oi", Output_i, 1000);
    chk("unity_oq", Output_q, -1000);
    chk("unity_cnt", Sat_count, 0);
    chk("unity_oi4", Output_i4, 1000);
    chk("unity_oq4", Output_q4, -1000);
    chk("unity_vout4", Valid_out4, 1);
    tick();
    chk("unity_pulse_end", Valid_out, 0);
    chk("unity_hold_oi", Output_i, 1000);

    // Rounding at gain 0.5: half-up toward +inf
    load_gain(16'd2048);
    send(26'sd3, -26'sd3);
    tick();
    tick();
    tick();
    chk("rnd3_oi", Output_i, 2);
    chk("rnd3_oq", Output_q, -1);
    send(26'sd1, -26'sd1);
    tick();
    tick();
    tick();
    chk("rnd1_oi", Output_i, 1);
    chk("rnd1_oq", Output_q, 0);

    // Saturation at gain 2.0
    load_gain(16'd8192);
    send(BIG_P, BIG_N);
    tick();
    tick();
    tick();
    chk("sat_oi", Output_i, MAXV);
    chk("sat_oq", Output_q, MINV);
    chk("sat_cnt1", Sat_count, 1);

    // Three more clipping samples back-to-back
    Input_i = BIG_P;
    Input_q = BIG_N;
    Valid   = 1'b1;
    tick();
    tick();
    tick();
    Valid = 1'b0;
    tick();
    chk("b2b_vout0", Valid_out, 1);
    chk("b2b_cnt2", Sat_count, 2);
    tick();
    chk("b2b_vout1", Valid_out, 1);
    chk("b2b_cnt3", Sat_count, 3);
    tick();
    chk("b2b_vout2", Valid_out, 1);
    chk("b2b_cnt4", Sat_count, 4);
    chk("b2b_cnt4_small", Sat_count4, 4);

    // Gain update on the same edge as a sample: that sample keeps the old gain
    load_gain(16'd4096);
    Gain       = 16'd8192;
    Gain_valid = 1'b1;
    Input_i    = 26'sd100;
    Input_q    = -26'sd50;
    Valid      = 1'b1;
    tick();
    Gain_valid = 1'b0;
    tick();
    Valid = 1'b0;
    tick();
    tick();
    chk("coll_old_oi", Output_i, 100);
    chk("coll_old_oq", Output_q, -50);
    tick();
    chk("coll_new_oi", Output_i, 200);
    chk("coll_new_oq", Output_q, -100);
    chk("coll_cnt", Sat_count, 4);

    // 20 clipping samples: 16-bit counter reaches 24, 4-bit counter sticks at 15
    Input_i = BIG_P;
    Input_q = 26'sd0;
    Valid   = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    Valid = 1'b0;
    tick();
    tick();
    tick();
    chk("stick_cnt16", Sat_count, 24);
    chk("stick_cnt4", Sat_count4, 15);

    // Sat_clear on the same edge as a clip increment
    send(BIG_P, 26'sd0);
    tick();
    tick();
    Sat_clear = 1'b1;
    tick();
    Sat_clear = 1'b0;
    chk("clr_vout", Valid_out, 1);
    chk("clr_oi", Output_i, MAXV);
    chk("clr_cnt", Sat_count, 0);
    chk("clr_cnt4", Sat_count4, 0);

    // Zero gain: zero output, no clip
    load_gain(16'd0);
    send(26'sd12345, -26'sd999);
    tick();
    tick();
    tick();
    chk("g0_oi", Output_i, 0);
    chk("g0_oq", Output_q, 0);
    chk("g0_cnt", Sat_count, 0);

    // Reset with three samples in flight
    load_gain(16'd8192);
    Input_i = 26'sd5;
    Input_q = -26'sd5;
    Valid   = 1'b1;
    tick();
    tick();
    tick();
    Valid = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vout", Valid_out, 0);
    chk("mid_rst_oi", Output_i, 0);
    chk("mid_rst_oq", Output_q, 0);
    send(26'sd7, -26'sd7);
    chk("mid_rst_flush0", Valid_out, 0);
    tick();
    chk("mid_rst_flush1", Valid_out, 0);
    tick();
    tick();
    chk("post_rst_vout", Valid_out, 1);
    chk("post_rst_oi", Output_i, 7);
    chk("post_rst_oq", Output_q, -7);
    chk("post_rst_cnt", Sat_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iq_gain_apply.md
Name: iq_gain_apply

Overview:
- Forward-path gain stage of the AGC loop, the other end of the envelope measurement.
- The magnitude/EMA chain measures |I|+|Q| and computes a gain. This block applies that gain back to the I/Q sample stream.
- Each sample is scaled by an unsigned fixed-point gain, then rounded and saturated to the output width. Clip events are counted for loop monitoring.
- Gain updates are registered and take effect on a defined sample boundary.

Parameters:
- W_IN, 26, signed width of Input_i/Input_q.
- W_GAIN, 16, unsigned gain width.
- GAIN_FRAC, 12, fractional bits of gain; unity = 2^GAIN_FRAC; must be ≥1.
- W_OUT, 26, signed width of Output_i/Output_q.
- W_CNT, 16, width of saturation counter.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- Input_i, input, W_IN, signed I sample.
- Input_q, input, W_IN, signed Q sample.
- Valid, input, 1, sample strobe; one sample per high cycle; no backpressure.
- Gain, input, W_GAIN, unsigned gain, Q(W_GAIN-GAIN_FRAC).GAIN_FRAC.
- Gain_valid, input, 1, load strobe for Gain.
- Sat_clear, input, 1, clears Sat_count.
- Output_i, output, W_OUT, scaled, rounded, saturated I.
- Output_q, output, W_OUT, scaled, rounded, saturated Q.
- Valid_out, output, 1, marks Output_i/Output_q valid.
- Sat_count, output, W_CNT, number of clipped samples; sticks at all-ones.

Behaviour:
- Reset is synchronous, active-high, and clk is the only clock.
- Reset values:
  - All stage valid flags 0, so Valid_out = 0.
  - Output_i = Output_q = 0.
  - Sat_count = 0.
  - Gain register = 2^GAIN_FRAC (unity).
- Pipeline, 3 cycles fixed latency: Valid high at edge N gives Valid_out high for exactly one cycle after edge N+3.
  - S1: register Input_i, Input_q, Valid, and the gain currently in effect.
  - S2: signed product, width W_IN+W_GAIN+1, using the zero-extended gain.
  - S3: round, saturate, register outputs and flag.
- Gain register:
  - Loads Gain when Gain_valid = 1.
  - A sample captured on the same edge as Gain_valid uses the OLD gain.
  - The new gain applies from the next accepted sample.
  - The gain register is not pipelined with samples beyond S1 capture.
- Rounding: add 2^(GAIN_FRAC-1) to the product, then arithmetic shift right by GAIN_FRAC. This is round-half-up toward +inf, so -1.5 → -1 and +1.5 → 2.
- Saturation:
  - A result above 2^(W_OUT-1)-1 clamps to that value.
  - A result below -2^(W_OUT-1) clamps to that value.
  - Each channel is evaluated independently.
- Clip flag: set in S3 if either channel clipped.
- Sat_count:
  - Increments by 1 per valid output sample with the clip flag set; a sample where both channels clip counts once.
  - Holds at 2^W_CNT-1; no wrap.
- Sat_clear:
  - Zeroes the counter on the next edge.
  - If asserted together with an increment, clear wins and the result is 0.
- Outputs update only when S3 is valid. Otherwise they hold their last value while Valid_out = 0.
- Gain = 0 gives outputs of 0 with no clip.
- Reset mid-stream: in-flight samples are discarded and no Valid_out pulse follows reset. A Valid in the first cycle after reset deasserts is accepted normally.
- Back-to-back Valid at full rate is supported, giving one output per cycle.

Decomposition:
- Shared package agc_pkg holds:
  - Default widths W_IN, W_GAIN, GAIN_FRAC, W_OUT.
  - A unity-gain constant function or localparam.
  - Saturation-limit constants.
- Sub-module mul_round_sat: one channel covering multiply, round, and saturate over S2–S3, with a clip flag output.
  - Instantiated twice, once for I and once for Q.
  - The top level owns the gain register, the valid pipeline, and Sat_count.

Test Plan:
- Reset then unity gain: I=1000, Q=-1000 with Valid at edge N → at N+3, Output_i=1000, Output_q=-1000, Valid_out high for 1 cycle, Sat_count=0.
- Rounding: Gain=2048 (0.5), I=3, Q=-3 → Output_i=2, Output_q=-1; I=1, Q=-1 → 1, 0.
- Saturation: Gain=8192 (2.0), I=2^24, Q=-2^24 → Output_i=33554431, Output_q=-33554432; Sat_count=1. Repeat 3 more times → Sat_count=4.
- Gain update collision: Gain_valid with Gain=8192 on the same edge as Valid with I=100 → output 200 is wrong and unity gives 100. That sample yields 100; the next sample I=100 yields 200.
- Counter boundaries:
  - W_CNT=4 with 20 clipping samples → Sat_count sticks at 15.
  - Sat_clear coincident with a clip → Sat_count=0.
- Reset mid-stream: 3 samples in flight, assert rst for 1 cycle → no Valid_out, outputs 0, gain back to unity. Next sample I=7 → Output_i=7 after 3 cycles.
